// File: rtl/ex_branch_jump_if.sv
// ex_branch_jump_if: issue, redirect, CDB and status signals of the branch/jump
// execution unit. The slave modport is the unit itself; the master modport is
// the reservation station / fetch / CDB arbiter side.
interface ex_branch_jump_if;
   logic          ex_en;
   logic [111:0]  rs2exe;
   logic          stall;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          cdb_req;
   logic          cdb_grant;
   logic [37:0]   cdb;
   logic          overflow;
   logic [31:0]   stat_exec;
   logic [31:0]   stat_taken;

   modport master (
      output ex_en, rs2exe, cdb_grant,
      input  stall, redirect_valid, redirect_pc, cdb_req, cdb, overflow,
             stat_exec, stat_taken
   );

   modport slave (
      input  ex_en, rs2exe, cdb_grant,
      output stall, redirect_valid, redirect_pc, cdb_req, cdb, overflow,
             stat_exec, stat_taken
   );
endinterface

// File: rtl/ex_branch_jump.sv
// ex_branch_jump: branch/jump execution unit.
// Resolves condition, target and link data in one registered stage, pulses a
// redirect to fetch, and queues {dest, data} in a DEPTH-entry FIFO that is
// broadcast on the CDB under arbiter grant.
// Optional macro BJ_STATS_EN adds executed-op and taken counters; without it
// stat_exec/stat_taken are tied to zero.
module ex_branch_jump #(
   parameter int DEPTH = 4
) (
   input logic             clk,
   input logic             reset,
   input logic             kill,
   ex_branch_jump_if.slave bus
);

   localparam int DATA_W = 32;
   localparam int TAG_W  = 6;
   localparam int CDB_W  = TAG_W + DATA_W;
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = PW + 1;
   localparam int OCC_W  = CW + 1;
   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
   localparam logic [OCC_W-1:0] STALL_TH = OCC_W'(DEPTH - 1);

   // Branch condition; jumps are unconditionally taken, NOP opcodes never are.
   function automatic logic br_taken(input logic [3:0] op,
                                     input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
      logic t;
      case (op)
         4'd0:    t = (a == b);
         4'd1:    t = (a != b);
         4'd2:    t = (a < b);
         4'd3:    t = (a >= b);
         4'd4:    t = ($unsigned(a) < $unsigned(b));
         4'd5:    t = ($unsigned(a) >= $unsigned(b));
         4'd6,
         4'd7:    t = 1'b1;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // JALR target: wrapping add with bit 0 forced clear.
   function automatic logic [DATA_W-1:0] jalr_target(input logic [DATA_W-1:0] base,
                                                     input logic [DATA_W-1:0] off);
      return (base + off) & ~DATA_W'(1);
   endfunction

   // ---------------- stage 0: decode and resolve ----------------
   logic [3:0]               w_op;
   logic [TAG_W-1:0]         w_dest;
   logic signed [DATA_W-1:0] w_opr1;
   logic signed [DATA_W-1:0] w_opr2;
   logic [DATA_W-1:0]        w_addr;
   logic                     w_nop;
   logic                     w_taken;
   logic [DATA_W-1:0]        w_target;
   logic [DATA_W-1:0]        w_data;
   logic                     w_unused_type;

   assign w_op          = bus.rs2exe[105:102];
   assign w_dest        = bus.rs2exe[101:96];
   assign w_opr1        = $signed(bus.rs2exe[95:64]);
   assign w_opr2        = $signed(bus.rs2exe[63:32]);
   assign w_addr        = bus.rs2exe[31:0];
   assign w_unused_type = ^bus.rs2exe[111:106];
   assign w_nop         = w_op[3];
   assign w_taken       = br_taken(w_op, w_opr1, w_opr2);

   // Select target and result data by opcode class.
   always_comb begin
      w_target = w_addr;
      w_data   = '0;
      case (w_op)
         4'd6: w_data = $unsigned(w_opr1);
         4'd7: begin
            w_target = jalr_target($unsigned(w_opr1), w_addr);
            w_data   = $unsigned(w_opr2);
         end
         default: begin
            if (!w_nop) w_data = {{(DATA_W-1){1'b0}}, w_taken};
         end
      endcase
   end

   // ---------------- stage 1: registered result (S1) ----------------
   logic                r_vld_p1;
   logic                r_nop_p1;
   logic                r_taken_p1;
   logic [DATA_W-1:0]   r_target_p1;
   logic [DATA_W-1:0]   r_data_p1;
   logic [TAG_W-1:0]    r_dest_p1;

   // S1 valid follows ex_en; flush clears it.
   always_ff @(posedge clk) begin
      if (reset || kill) r_vld_p1 <= 1'b0;
      else               r_vld_p1 <= bus.ex_en;
   end

   // S1 payload is only meaningful under r_vld_p1, so it carries no reset.
   always_ff @(posedge clk) begin
      if (bus.ex_en) begin
         r_nop_p1    <= w_nop;
         r_taken_p1  <= w_taken;
         r_target_p1 <= w_target;
         r_data_p1   <= w_data;
         r_dest_p1   <= w_dest;
      end
   end

   // A live S1 entry is a valid non-NOP op not being flushed this cycle.
   logic w_live_p1;
   logic w_redirect;
   assign w_live_p1  = r_vld_p1 & ~r_nop_p1 & ~reset & ~kill;
   assign w_redirect = w_live_p1 & r_taken_p1;

   assign bus.redirect_valid = w_redirect;
   assign bus.redirect_pc    = w_redirect ? r_target_p1 : '0;

   // ---------------- stage 2: result FIFO and CDB ----------------
   logic [CDB_W-1:0]  r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_wr;
   logic              w_drop;
   logic [OCC_W-1:0]  w_occ;

   assign w_push = w_live_p1 & (r_dest_p1 != '0);
   assign w_pop  = (r_count != '0) & bus.cdb_grant;
   assign w_full = (r_count == FULL_CNT);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_wr   = w_push & (~w_full | w_pop);
   assign w_drop = w_push & w_full & ~w_pop;
   // Occupancy includes the S1 result about to be pushed.
   assign w_occ  = OCC_W'(r_count) + OCC_W'(w_push);

   // Pointers, count and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset || kill) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // FIFO storage write.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {r_dest_p1, r_data_p1};
   end

   assign bus.cdb_req  = (r_count != '0);
   assign bus.cdb      = w_pop ? r_mem[r_rd_ptr] : '0;
   assign bus.stall    = (w_occ >= STALL_TH);
   assign bus.overflow = r_overflow;

`ifdef BJ_STATS_EN
   logic [31:0] r_stat_exec;
   logic [31:0] r_stat_taken;

   // Wrapping counters; cleared by reset only, kill leaves them running.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_exec  <= '0;
         r_stat_taken <= '0;
      end else begin
         if (r_vld_p1 && !r_nop_p1) r_stat_exec  <= r_stat_exec + 32'd1;
         if (w_redirect)            r_stat_taken <= r_stat_taken + 32'd1;
      end
   end

   assign bus.stat_exec  = r_stat_exec;
   assign bus.stat_taken = r_stat_taken;
`else
   assign bus.stat_exec  = '0;
   assign bus.stat_taken = '0;
`endif

endmodule

// File: tb/tb_ex_branch_jump.sv
// tb_ex_branch_jump: self-checking bench for ex_branch_jump. Expected CDB
// entries are queued when ops are issued and compared as the DUT grants them.
module tb_ex_branch_jump;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   logic kill;
   int   checks = 0;
   int   errors = 0;
   logic [37:0] sb [$];

   always #5 clk = ~clk;

   ex_branch_jump_if bus ();

   ex_branch_jump #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .kill  (kill),
      .bus   (bus.slave)
   );

   // Reference behaviour of one op.
   function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] ad,
                                 output logic tk, output logic [31:0] tg,
                                 output logic [31:0] d);
      tk = 1'b0; tg = ad; d = 32'h0;
      case (op)
         4'd0: tk = (a == b);
         4'd1: tk = (a != b);
         4'd2: tk = ($signed(a) < $signed(b));
         4'd3: tk = ($signed(a) >= $signed(b));
         4'd4: tk = (a < b);
         4'd5: tk = (a >= b);
         4'd6: begin tk = 1'b1; d = a; end
         4'd7: begin tk = 1'b1; tg = (a + ad) & 32'hFFFF_FFFE; d = b; end
         default: tk = 1'b0;
      endcase
      if (op < 4'd6) d = {31'b0, tk};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.ex_en  = 1'b0;
      bus.rs2exe = '0;
   endtask

   // Present one op; queue its expected CDB entry when it should reach the FIFO.
   task automatic drive(input logic [3:0] op, input logic [5:0] dest,
                        input logic [31:0] o1, input logic [31:0] o2,
                        input logic [31:0] ad, input bit expect_push);
      logic tk;
      logic [31:0] tg, d;
      model(op, o1, o2, ad, tk, tg, d);
      bus.ex_en  = 1'b1;
      bus.rs2exe = {6'h2A, op, dest, o1, o2, ad};
      if (expect_push && op < 4'd8 && dest != 6'd0 && sb.size() < DEPTH)
         sb.push_back({dest, d});
   endtask

   // CDB scoreboard: every granted beat must match the oldest queued result.
   always @(negedge clk) begin
      if (!reset && !kill) begin
         checks++;
         if (bus.cdb_req && bus.cdb_grant) begin
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL cdb_unexpected got=%h required=none", bus.cdb);
            end else begin
               logic [37:0] exp_v;
               exp_v = sb.pop_front();
               if (bus.cdb !== exp_v) begin
                  errors++;
                  $display("FAIL cdb_data got=%h required=%h", bus.cdb, exp_v);
               end
            end
         end else if (bus.cdb !== 38'h0) begin
            errors++;
            $display("FAIL cdb_idle got=%h required=0", bus.cdb);
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; kill = 1'b0; bus.cdb_grant = 1'b0; idle();
      step(); step();
      reset = 1'b0;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b required=0", bus.stall); end
      checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect got=%b/%h required=0/0", bus.redirect_valid, bus.redirect_pc); end
      checks++; if (bus.cdb_req !== 1'b0 || bus.cdb !== 38'h0) begin errors++; $display("FAIL rst_cdb got=%b/%h required=0/0", bus.cdb_req, bus.cdb); end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b required=0", bus.overflow); end
      checks++; if (bus.stat_exec !== 32'h0 || bus.stat_taken !== 32'h0) begin errors++; $display("FAIL rst_stats got=%h/%h required=0/0", bus.stat_exec, bus.stat_taken); end
   endtask

   task automatic test_beq();
      bus.cdb_grant = 1'b1;
      drive(4'd0, 6'd3, 32'd5, 32'd5, 32'h100, 1'b1);
      step(); idle();
      checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h100) begin errors++; $display("FAIL beq_redirect got=%b/%h required=1/00000100", bus.redirect_valid, bus.redirect_pc); end
      step();
      checks++; if (bus.cdb !== {6'd3, 32'h1}) begin errors++; $display("FAIL beq_cdb got=%h required=%h", bus.cdb, {6'd3, 32'h1}); end
      checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL beq_pulse got=%b/%h required=0/0", bus.redirect_valid, bus.redirect_pc); end
      step();
   endtask

   task automatic test_signed_cmp();
      bus.cdb_grant = 1'b1;
      drive(4'd2, 6'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b1);
      step();
      drive(4'd4, 6'd5, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b1);
      checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200) begin errors++; $display("FAIL blt_redirect got=%b/%h required=1/00000200", bus.redirect_valid, bus.redirect_pc); end
      step(); idle();
      checks++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL bltu_redirect got=%b/%h required=0/0", bus.redirect_valid, bus.redirect_pc); end
      step(); step(); step();
   endtask

   task automatic test_jalr();
      bus.cdb_grant = 1'b1;
      drive(4'd7, 6'd7, 32'h1003, 32'h2008, 32'h4, 1'b1);
      step(); idle();
      checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1006) begin errors++; $display("FAIL jalr_redirect got=%b/%h required=1/00001006", bus.redirect_valid, bus.redirect_pc); end
      step();
      checks++; if (bus.cdb !== {6'd7, 32'h2008}) begin errors++; $display("FAIL jalr_cdb got=%h required=%h", bus.cdb, {6'd7, 32'h2008}); end
      step();
   endtask

   task automatic test_nop();
      bus.cdb_grant = 1'b1;
      drive(4'hC, 6'd5, 32'd1, 32'd1, 32'h500, 1'b1);
      step(); idle();
      checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL nop_redirect got=%b required=0", bus.redirect_valid); end
      step();
      checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL nop_cdb_req got=%b required=0", bus.cdb_req); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [3:0]  op;
      logic [31:0] a, b, ad, tg, d;
      logic        tk;
      bus.cdb_grant = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op = 4'($urandom_range(0, 9));
         a  = $urandom();
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
         ad = $urandom();
         if (i == 0) begin op = 4'd7; a = 32'hFFFF_FFFF; ad = 32'h3; end
         model(op, a, b, ad, tk, tg, d);
         drive(op, 6'(i + 1), a, b, ad, 1'b1);
         step();
         checks++;
         if (bus.redirect_valid !== (op < 4'd8 && tk) ||
             bus.redirect_pc !== ((op < 4'd8 && tk) ? tg : 32'h0)) begin
            errors++;
            $display("FAIL b2b_redirect[%0d] op=%0d got=%b/%h required=%b/%h", i, op,
                     bus.redirect_valid, bus.redirect_pc, (op < 4'd8 && tk),
                     (op < 4'd8 && tk) ? tg : 32'h0);
         end
      end
      idle();
      step(); step(); step();
   endtask

   task automatic test_stall_drain();
      bus.cdb_grant = 1'b0;
      drive(4'd0, 6'd1, 32'd9, 32'd9, 32'h10, 1'b1);
      step();
      drive(4'd1, 6'd2, 32'd9, 32'd9, 32'h20, 1'b1);
      step(); idle(); step(); step();
      checks++; if (bus.stall !== 1'b0 || bus.cdb_req !== 1'b1) begin errors++; $display("FAIL stall_two got=%b/%b required=0/1", bus.stall, bus.cdb_req); end
      drive(4'd6, 6'd3, 32'hAAAA, 32'd0, 32'h30, 1'b1);
      step(); idle(); step();
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL stall_three got=%b required=1", bus.stall); end
      checks++; if (bus.cdb !== 38'h0) begin errors++; $display("FAIL stall_cdb_nogrant got=%h required=0", bus.cdb); end
      bus.cdb_grant = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         #1;
         checks++; if (bus.cdb[37:32] !== 6'(k)) begin errors++; $display("FAIL drain_tag[%0d] got=%0d required=%0d", k, bus.cdb[37:32], k); end
         step();
      end
      checks++; if (bus.cdb_req !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b/%b required=0/0", bus.cdb_req, bus.stall); end
   endtask

   task automatic test_overflow();
      bus.cdb_grant = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive(4'd6, 6'(i + 1), 32'h100 + 32'(i), 32'd0, 32'h40, 1'b1);
         step();
      end
      idle(); step(); step();
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b required=1", bus.overflow); end
      checks++; if (bus.cdb_req !== 1'b1 || bus.stall !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b/%b required=1/1", bus.cdb_req, bus.stall); end
      bus.cdb_grant = 1'b1;
      for (int i = 0; i < DEPTH; i++) step();
      checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b required=0", bus.cdb_req); end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b required=1", bus.overflow); end
      bus.cdb_grant = 1'b0;
   endtask

   task automatic test_kill();
      bus.cdb_grant = 1'b0;
      drive(4'd6, 6'd8, 32'h8, 32'd0, 32'h50, 1'b0);
      step();
      drive(4'd6, 6'd9, 32'h9, 32'd0, 32'h60, 1'b0);
      step(); idle(); step();
      checks++; if (bus.cdb_req !== 1'b1) begin errors++; $display("FAIL kill_prefill got=%b required=1", bus.cdb_req); end
      drive(4'd6, 6'd10, 32'hA, 32'd0, 32'h70, 1'b0);
      step(); idle();
      kill = 1'b1;
      #1;
      checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL kill_redirect got=%b required=0", bus.redirect_valid); end
      step();
      kill = 1'b0;
      sb.delete();
      checks++; if (bus.cdb_req !== 1'b0 || bus.overflow !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL kill_clear got=%b/%b/%b required=0/0/0", bus.cdb_req, bus.overflow, bus.stall); end
      step(); step();
      checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL kill_s1_push got=%b required=0", bus.cdb_req); end
   endtask

   task automatic test_jal_dest0_stats();
      reset = 1'b1; bus.cdb_grant = 1'b1; idle();
      step();
      reset = 1'b0;
      sb.delete();
      drive(4'd6, 6'd0, 32'h44, 32'd0, 32'h800, 1'b1);
      step(); idle();
      checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h800) begin errors++; $display("FAIL jal0_redirect got=%b/%h required=1/00000800", bus.redirect_valid, bus.redirect_pc); end
      step();
      checks++; if (bus.cdb_req !== 1'b0) begin errors++; $display("FAIL jal0_cdb_req got=%b required=0", bus.cdb_req); end
`ifdef BJ_STATS_EN
      checks++; if (bus.stat_exec !== 32'd1 || bus.stat_taken !== 32'd1) begin errors++; $display("FAIL stats got=%0d/%0d required=1/1", bus.stat_exec, bus.stat_taken); end
`else
      checks++; if (bus.stat_exec !== 32'd0 || bus.stat_taken !== 32'd0) begin errors++; $display("FAIL stats_tied got=%0d/%0d required=0/0", bus.stat_exec, bus.stat_taken); end
`endif
   endtask

   initial begin
      reset = 1'b1;
      kill  = 1'b0;
      bus.cdb_grant = 1'b0;
      bus.ex_en     = 1'b0;
      bus.rs2exe    = '0;
      test_reset();
      test_beq();
      test_signed_cmp();
      test_jalr();
      test_nop();
      test_back_to_back();
      test_stall_drain();
      test_overflow();
      test_kill();
      test_jal_dest0_stats();
      step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got=%0d required=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
